uart_operand_loader: RTL and testbench
======================================

Name: uart_operand_loader

Overview:
- Parametrised successor to the two-buffer UART loader for the systolic Booth multiplier.
- Collects a UART byte stream into N_CH on-chip operand buffers, each DEPTH words of DATA_W bits, filled one channel after another.
- Once all buffers are full, streams every channel out in lockstep under a valid/ready handshake to the systolic array.
- Runs on one clock, downstream of uart_rx, whose enable-qualified data_valid drives i_byte_valid. Adds multi-byte word assembly, a handshake, overrun detection, replay and soft clear.

Parameters:
- DATA_W, 8, operand word width in bits; must be a multiple of 8 (elaboration error otherwise).
- DEPTH, 16, words per channel; at least 2.
- N_CH, 2, number of operand channels (matrix A, matrix B, ...); at least 1.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- i_byte  in  8  received UART byte.
- i_byte_valid  in  1  one-cycle strobe; i_byte is accepted on this cycle.
- i_clear  in  1  synchronous soft clear.
- i_replay  in  1  re-stream the stored buffers without reloading.
- o_data  out  N_CH*DATA_W  lockstep words; channel c occupies bits [c*DATA_W +: DATA_W].
- o_valid  out  1  o_data is valid.
- i_ready  in  1  consumer accepts the word when o_valid && i_ready.
- o_last  out  1  high with word index DEPTH-1.
- o_loaded  out  1  one-cycle pulse when the final byte has been stored.
- o_busy  out  1  high in STREAM.
- o_overrun  out  1  sticky; a byte arrived outside LOAD.

Behaviour:
- Reset (reset=0, asynchronous): state LOAD; all pointers zero; o_valid, o_last, o_loaded, o_busy and o_overrun all 0; o_data 0. Buffer contents are undefined.
- Derived values: BPW = DATA_W/8. Total load = N_CH*DEPTH*BPW bytes.
- Word assembly: little-endian. The first byte of each word goes to bits [7:0]. The word is written to the buffer on the cycle its BPW-th byte is accepted.
- Fill order: channel 0 words 0..DEPTH-1, then channel 1, and so on.
- LOAD state: each accepted byte advances the byte, word and channel counters.
  - The final byte is accepted in cycle T. o_loaded pulses at T+1 and the state becomes STREAM at T+1.
- STREAM state:
  - o_busy=1.
  - Buffer reads are synchronous, one cycle of latency.
  - The first o_valid with word 0 appears at T+2.
  - On each o_valid && i_ready the word index advances. The next word is presented on the following cycle with no bubble; a prefetch or skid register is required.
  - While i_ready=0, o_data, o_valid and o_last hold stable.
  - o_last=1 only with word DEPTH-1.
  - The handshake on the last word at cycle U returns the state to LOAD at U+1, with o_valid=0 and all pointers zero.
- Replay: i_replay=1 in LOAD with the byte counter at zero enters STREAM the next cycle, reading the existing contents. No o_loaded pulse is generated. i_replay is ignored at any other time.
- Overrun: i_byte_valid in STREAM drops the byte and sets o_overrun. o_overrun clears only on reset or i_clear.
- i_clear, any state: the next cycle is LOAD with pointers zero, o_valid=0, o_busy=0 and o_overrun=0. Buffer contents are kept.
  - i_clear wins over a simultaneous i_byte_valid or i_replay; that byte is dropped.
- Partial word at clear: the assembled bytes are discarded.
- Wrap: counters use ADDR_W = clog2(DEPTH) bits. Non-power-of-two DEPTH compares against DEPTH-1 explicitly; the counters never wrap naturally.

Decomposition:
- Package uart_loader_pkg:
  - state enum {LOAD, STREAM};
  - functions computing BPW, ADDR_W and CH_W from the parameters;
  - constant BYTE_W=8.
- Sub-module loader_ram: simple dual-port RAM, width DATA_W, depth DEPTH, registered read, written as BRAM-inferable. Instantiated N_CH times inside a generate loop.
- The top level holds the FSM, the assembler, the counters and the output skid.

Test Plan:
- Defaults (8/16/2): send bytes 0x00..0x1F with i_ready=1.
  - o_loaded pulses exactly once.
  - 16 beats appear, beat k = {ch1=0x10+k, ch0=k}.
  - o_last on beat 15; back in LOAD on the next cycle.
- DATA_W=16, DEPTH=4, N_CH=3: send bytes 0x01..0x18.
  - ch0 word0=0x0201; ch2 word3=0x1817.
  - 4 beats out.
- Backpressure: drop i_ready for 3 cycles at beat 5 (defaults).
  - o_data and o_valid hold at beat 5.
  - No beat is lost or duplicated; 16 total.
- Overrun then clear: a byte 0xAA during STREAM sets o_overrun, and the stream is unchanged.
  - A later i_clear drops o_overrun and o_valid next cycle.
- Replay: after a full stream, pulse i_replay.
  - An identical 16-beat sequence appears with no o_loaded.
  - i_replay after one byte of a new load is ignored.
- Reset mid-load: assert reset after 10 bytes, then send 32 fresh bytes.
  - Outputs are 0 during reset.
  - The stream reflects only the new bytes.

Source files
------------

// File: rtl/uart_operand_loader_pkg.sv
// Shared types and elaboration helpers for the UART operand loader.
package uart_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_bpw(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic int calc_addr_w(input int depth);
    return calc_cnt_w(depth);
  endfunction

  function automatic int calc_ch_w(input int n_ch);
    return calc_cnt_w(n_ch);
  endfunction

endpackage

// File: rtl/uart_operand_loader_ram.sv
// Simple dual-port operand buffer with registered read, shaped for block-RAM inference.
module loader_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/uart_operand_loader.sv
// Fills N_CH operand buffers from a UART byte stream, then streams all channels in
// lockstep over valid/ready; a two-slot output/skid pair keeps the stream bubble-free.
module uart_operand_loader
  import uart_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int N_CH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BYTE_W-1:0]      i_byte,
  input  logic                   i_byte_valid,
  input  logic                   i_clear,
  input  logic                   i_replay,
  output logic [N_CH*DATA_W-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic                   o_loaded,
  output logic                   o_busy,
  output logic                   o_overrun
);

  localparam int BPW    = calc_bpw(DATA_W);
  localparam int ADDR_W = calc_addr_w(DEPTH);
  localparam int CH_W   = calc_ch_w(N_CH);
  localparam int BC_W   = calc_cnt_w(BPW);
  localparam int OUT_W  = N_CH * DATA_W;

  if ((DATA_W % BYTE_W) != 0 || DATA_W < BYTE_W) begin : g_bad_data_w
    $error("uart_operand_loader: DATA_W must be a positive multiple of 8");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("uart_operand_loader: DEPTH must be at least 2");
  end
  if (N_CH < 1) begin : g_bad_n_ch
    $error("uart_operand_loader: N_CH must be at least 1");
  end

  state_e            state_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [ADDR_W-1:0] word_q;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] asm_q;
  logic [ADDR_W-1:0] fetch_ptr_q;
  logic              fetch_done_q;
  logic              ram_v_q;
  logic              ram_last_q;
  logic              skid_v_q;
  logic              skid_last_q;
  logic [OUT_W-1:0]  skid_data_q;
  logic              out_v_q;
  logic              out_last_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              loaded_q;
  logic              overrun_q;

  logic              load_empty_s;
  logic              replay_s;
  logic              accept_s;
  logic              word_end_s;
  logic              final_s;
  logic              start_s;
  logic              pop_s;
  logic              end_s;
  logic              out_free_s;
  logic [1:0]        occ_s;
  logic              issue_s;
  logic [DATA_W-1:0] wdata_s;
  logic [N_CH-1:0]   we_s;
  logic [OUT_W-1:0]  rdata_s;

  // Handshake strobes, fetch credit and the assembled write word.
  always_comb begin
    load_empty_s = (byte_cnt_q == '0) && (word_q == '0) && (ch_q == '0);
    replay_s     = i_replay && !i_clear && (state_q == LOAD) && load_empty_s;
    accept_s     = i_byte_valid && !i_clear && (state_q == LOAD) && !replay_s;
    word_end_s   = accept_s && (byte_cnt_q == BC_W'(BPW - 1));
    final_s      = word_end_s && (word_q == ADDR_W'(DEPTH - 1)) && (ch_q == CH_W'(N_CH - 1));
    start_s      = final_s || replay_s;
    pop_s        = out_v_q && i_ready;
    end_s        = pop_s && out_last_q;
    out_free_s   = !out_v_q || pop_s;
    // Words held or arriving after this edge; a new read may issue only if a slot stays free.
    occ_s        = 2'(out_v_q) + 2'(skid_v_q) + 2'(ram_v_q) - 2'(pop_s);
    issue_s      = !i_clear &&
                   (start_s || ((state_q == STREAM) && !fetch_done_q && (occ_s <= 2'd1)));
    wdata_s      = asm_q;
    wdata_s[DATA_W-BYTE_W +: BYTE_W] = i_byte;
  end

  // Loader FSM, byte assembler, counters, fetch pointer and output skid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      ch_q         <= '0;
      asm_q        <= '0;
      fetch_ptr_q  <= '0;
      fetch_done_q <= 1'b0;
      ram_v_q      <= 1'b0;
      ram_last_q   <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      out_v_q      <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      loaded_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (i_clear) begin
      state_q      <= LOAD;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      ch_q         <= '0;
      asm_q        <= '0;
      fetch_ptr_q  <= '0;
      fetch_done_q <= 1'b0;
      ram_v_q      <= 1'b0;
      ram_last_q   <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      out_v_q      <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      loaded_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      loaded_q <= final_s;
      if ((state_q == STREAM) && i_byte_valid) begin
        overrun_q <= 1'b1;
      end

      if (accept_s) begin
        asm_q[BYTE_W*int'(byte_cnt_q) +: BYTE_W] <= i_byte;
        if (word_end_s) begin
          byte_cnt_q <= '0;
          if (word_q == ADDR_W'(DEPTH - 1)) begin
            word_q <= '0;
            ch_q   <= (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
          end else begin
            word_q <= word_q + 1'b1;
          end
        end else begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end

      if (start_s) begin
        state_q <= STREAM;
      end else if (end_s) begin
        state_q <= LOAD;
      end

      // The first read is issued alongside the start so word 0 lands two cycles later.
      if (end_s) begin
        fetch_ptr_q  <= '0;
        fetch_done_q <= 1'b0;
      end else if (issue_s) begin
        if (fetch_ptr_q == ADDR_W'(DEPTH - 1)) begin
          fetch_done_q <= 1'b1;
        end else begin
          fetch_ptr_q <= fetch_ptr_q + 1'b1;
        end
      end
      ram_v_q    <= issue_s;
      ram_last_q <= issue_s && (fetch_ptr_q == ADDR_W'(DEPTH - 1));

      if (out_free_s) begin
        if (skid_v_q) begin
          out_data_q  <= skid_data_q;
          out_v_q     <= 1'b1;
          out_last_q  <= skid_last_q;
          skid_v_q    <= ram_v_q;
          skid_last_q <= ram_last_q;
          if (ram_v_q) begin
            skid_data_q <= rdata_s;
          end
        end else if (ram_v_q) begin
          out_data_q <= rdata_s;
          out_v_q    <= 1'b1;
          out_last_q <= ram_last_q;
        end else begin
          out_v_q    <= 1'b0;
          out_last_q <= 1'b0;
        end
      end else if (ram_v_q) begin
        skid_data_q <= rdata_s;
        skid_v_q    <= 1'b1;
        skid_last_q <= ram_last_q;
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign we_s[c] = word_end_s && (ch_q == CH_W'(c));

    loader_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk     (clk),
      .we_i    (we_s[c]),
      .waddr_i (word_q),
      .wdata_i (wdata_s),
      .re_i    (issue_s),
      .raddr_i (fetch_ptr_q),
      .rdata_o (rdata_s[c*DATA_W +: DATA_W])
    );
  end

  assign o_data    = out_data_q;
  assign o_valid   = out_v_q;
  assign o_last    = out_last_q;
  assign o_loaded  = loaded_q;
  assign o_busy    = (state_q == STREAM);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_operand_loader.sv
// Directed bench for uart_operand_loader: default 8/16/2 instance plus a 16/4/3 instance.
module tb_uart_operand_loader;

  logic        clk;
  logic        rst_n;

  logic [7:0]  a_byte;
  logic        a_bv, a_clear, a_replay, a_ready;
  logic [15:0] a_data;
  logic        a_valid, a_last, a_loaded, a_busy, a_overrun;

  logic [7:0]  b_byte;
  logic        b_bv, b_clear, b_replay, b_ready;
  logic [47:0] b_data;
  logic        b_valid, b_last, b_loaded, b_busy, b_overrun;

  logic [7:0]  model_a [32];
  logic [7:0]  model_b [24];
  int          pos_a, pos_b;
  int          a_beat, a_total, loaded_cnt, b_beat, b_total;
  int          n_vec, n_err;
  logic        a_hold, a_end_seen;
  logic [15:0] a_prev;

  uart_operand_loader dut_a (
    .clk(clk), .reset(rst_n), .i_byte(a_byte), .i_byte_valid(a_bv), .i_clear(a_clear),
    .i_replay(a_replay), .o_data(a_data), .o_valid(a_valid), .i_ready(a_ready),
    .o_last(a_last), .o_loaded(a_loaded), .o_busy(a_busy), .o_overrun(a_overrun)
  );

  uart_operand_loader #(.DATA_W(16), .DEPTH(4), .N_CH(3)) dut_b (
    .clk(clk), .reset(rst_n), .i_byte(b_byte), .i_byte_valid(b_bv), .i_clear(b_clear),
    .i_replay(b_replay), .o_data(b_data), .o_valid(b_valid), .i_ready(b_ready),
    .o_last(b_last), .o_loaded(b_loaded), .o_busy(b_busy), .o_overrun(b_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of both DUTs against the byte-order model of the buffers.
  task automatic compare_cycle();
    logic [47:0] b_exp;
    if (!rst_n) begin
      a_beat = 0; a_hold = 1'b0; a_end_seen = 1'b0; b_beat = 0;
      return;
    end
    if (a_end_seen) begin
      chk("a_back_in_load", {a_busy, a_valid}, 2'b00);
      a_end_seen = 1'b0;
    end
    if (a_hold) begin
      chk("a_hold_valid", a_valid, 1'b1);
      chk("a_hold_data", a_data, a_prev);
    end
    if (a_valid) begin
      if (a_beat < 16) begin
        chk("a_beat_data", a_data, {model_a[16 + a_beat], model_a[a_beat]});
        chk("a_beat_last", a_last, a_beat == 15);
      end else begin
        chk("a_extra_beat", 1'b1, 1'b0);
      end
      if (a_ready) begin
        a_beat++; a_total++;
        if (a_beat == 16) begin
          a_end_seen = 1'b1;
          a_beat = 0;
        end
      end
    end else begin
      chk("a_last_idle", a_last, 1'b0);
    end
    if (a_loaded) loaded_cnt++;
    a_hold = a_valid && !a_ready;
    a_prev = a_data;
    if (!a_busy) a_beat = 0;

    if (b_valid) begin
      if (b_beat < 4) begin
        for (int c = 0; c < 3; c++)
          b_exp[c*16 +: 16] = {model_b[(c*4 + b_beat)*2 + 1], model_b[(c*4 + b_beat)*2]};
        chk("b_beat_data", b_data, b_exp);
        chk("b_beat_last", b_last, b_beat == 3);
      end else begin
        chk("b_extra_beat", 1'b1, 1'b0);
      end
      if (b_ready) begin
        b_beat++; b_total++;
      end
    end
    if (!b_busy) b_beat = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] v);
    a_byte = v; a_bv = 1'b1;
    model_a[pos_a] = v;
    pos_a = (pos_a + 1) % 32;
    tick();
    a_bv = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] v);
    b_byte = v; b_bv = 1'b1;
    model_b[pos_b] = v;
    pos_b = (pos_b + 1) % 24;
    tick();
    b_bv = 1'b0;
  endtask

  task automatic pulse_replay_a();
    a_replay = 1'b1;
    tick();
    a_replay = 1'b0;
  endtask

  task automatic wait_idle_a(input string name, input int t0);
    int g;
    g = 0;
    while (a_busy && g < 200) begin
      tick();
      g++;
    end
    tick();
    chk(name, a_total - t0, 16);
    chk({name, "_idle"}, {a_busy, a_valid}, 2'b00);
  endtask

  initial begin
    int t0, g;
    n_vec = 0; n_err = 0; pos_a = 0; pos_b = 0;
    a_beat = 0; a_total = 0; loaded_cnt = 0; b_beat = 0; b_total = 0;
    a_hold = 1'b0; a_end_seen = 1'b0; a_prev = 16'h0;
    a_byte = 8'h00; a_bv = 1'b0; a_clear = 1'b0; a_replay = 1'b0; a_ready = 1'b1;
    b_byte = 8'h00; b_bv = 1'b0; b_clear = 1'b0; b_replay = 1'b0; b_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ctl", {a_valid, a_last, a_loaded, a_busy, a_overrun}, 5'b0);
    chk("rst_a_data", a_data, 16'h0);
    chk("rst_b_ctl", {b_valid, b_last, b_loaded, b_busy, b_overrun}, 5'b0);
    chk("rst_b_data", b_data, 48'h0);
    rst_n = 1'b1;
    tick();

    // 16-bit words, 3 channels of 4
    for (int i = 0; i < 24; i++) send_b(8'(i + 1));
    chk("b_loaded", b_loaded, 1'b1);
    tick();
    chk("b_ch0_w0", b_data[15:0], 16'h0201);
    g = 0;
    while (b_beat != 3 && g < 20) begin tick(); g++; end
    chk("b_ch2_w3", b_data[47:32], 16'h1817);
    g = 0;
    while (b_busy && g < 20) begin tick(); g++; end
    chk("b_beats", b_total, 4);

    // Default instance, plain load and stream
    t0 = a_total;
    for (int i = 0; i < 32; i++) send_a(8'(i));
    chk("a_loaded_t1", {a_loaded, a_busy, a_valid}, 3'b110);
    tick();
    chk("a_first_beat", {a_valid, a_data}, {1'b1, 16'h1000});
    wait_idle_a("a_load1_beats", t0);
    chk("a_loaded_once", loaded_cnt, 1);

    // Backpressure at beat 5
    t0 = a_total;
    for (int i = 0; i < 32; i++) send_a(8'(8'h40 + i));
    g = 0;
    while (a_beat != 5 && g < 40) begin tick(); g++; end
    a_ready = 1'b0;
    chk("bp_beat5", {a_valid, a_data}, {1'b1, 16'h5545});
    repeat (3) tick();
    chk("bp_beat5_held", {a_valid, a_data}, {1'b1, 16'h5545});
    a_ready = 1'b1;
    wait_idle_a("bp_beats", t0);
    chk("bp_loaded_cnt", loaded_cnt, 2);

    // Replay with an overrun byte mid-stream
    t0 = a_total;
    pulse_replay_a();
    chk("replay_busy", a_busy, 1'b1);
    repeat (3) tick();
    a_byte = 8'hAA; a_bv = 1'b1;
    tick();
    a_bv = 1'b0;
    chk("overrun_set", a_overrun, 1'b1);
    wait_idle_a("replay_beats", t0);
    chk("replay_no_loaded", loaded_cnt, 2);
    chk("overrun_sticky", a_overrun, 1'b1);

    // Clear in the middle of a second replay
    pulse_replay_a();
    repeat (4) tick();
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("clear_next", {a_valid, a_busy, a_overrun}, 3'b000);

    // Replay after one byte of a new load must not start a stream
    send_a(8'h77);
    pulse_replay_a();
    tick();
    chk("replay_ignored", a_busy, 1'b0);
    for (int i = 1; i < 10; i++) send_a(8'(8'h77 + i));

    // Reset mid-load, then a fresh full load
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {a_valid, a_last, a_loaded, a_busy, a_overrun}, 5'b0);
    chk("midrst_data", a_data, 16'h0);
    tick();
    tick();
    chk("midrst_hold", {a_valid, a_busy, a_data}, 18'h0);
    rst_n = 1'b1;
    pos_a = 0;
    tick();
    t0 = a_total;
    for (int i = 0; i < 32; i++) send_a(8'(8'h80 + i));
    chk("fresh_loaded", a_loaded, 1'b1);
    tick();
    chk("fresh_first_beat", {a_valid, a_data}, {1'b1, 16'h9080});
    wait_idle_a("fresh_beats", t0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
